// File: rtl/num_seq_pkg.sv
// Shared types and helpers for the two-bit number sequencer.
package num_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Next code in the chosen direction; two-bit arithmetic gives the mod-4 wrap.
    function automatic logic [1:0] step_num(input logic [1:0] n, input logic d);
        return (d == DIR_DOWN) ? (n - 2'd1) : (n + 2'd1);
    endfunction

    // True when stepping from n in direction d crosses the 3/0 boundary.
    function automatic logic is_wrap(input logic [1:0] n, input logic d);
        return (d == DIR_DOWN) ? (n == 2'd0) : (n == 2'd3);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Reloadable down counter: ticks while running whenever it reaches zero,
// then reloads so each step lasts reload+1 cycles.
module dwell_timer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    input  logic               run_i,
    input  logic [DWELL_W-1:0] reload_val_i,
    output logic               tick_o
);

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign tick_o = run_i && (cnt_q == '0);

    // Next count: explicit load wins, otherwise count down and reload at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (run_i) begin
            if (cnt_q == '0) begin
                cnt_d = reload_val_i;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/num_sequencer.sv
// Two-bit number sequencer feeding a 2-to-4 decoder. Steps up or down every
// dwell+1 cycles, either continuously or for a single pass of four steps.
// Optional preset (load/load_val) is compiled in with NUM_SEQ_LOAD_EN.
module num_sequencer
    import num_seq_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
`ifdef NUM_SEQ_LOAD_EN
    input  logic               load,
    input  logic [1:0]         load_val,
`endif
    output logic [1:0]         num,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    state_e             state_q, state_d;
    logic [1:0]         num_q, num_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic               dir_q, dir_d;
    logic               single_q, single_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         steps_q, steps_d;
    logic               tmr_load;
    logic               tick;

    dwell_timer #(
        .DWELL_W(DWELL_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (tmr_load),
        .load_val_i  (dwell),
        .run_i       (state_q == RUN),
        .reload_val_i(dwell_q),
        .tick_o      (tick)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        wrap_d   = 1'b0;
        done_d   = 1'b0;
        dir_d    = dir_q;
        single_d = single_q;
        dwell_d  = dwell_q;
        steps_d  = steps_q;
        tmr_load = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef NUM_SEQ_LOAD_EN
                // A preset in the same cycle as start takes precedence.
                if (load) begin
                    num_d = load_val;
                end else
`endif
                if (start) begin
                    state_d  = RUN;
                    dir_d    = dir;
                    single_d = single;
                    dwell_d  = dwell;
                    steps_d  = 2'd0;
                    tmr_load = 1'b1;
                end
            end
            RUN: begin
                // Stop beats a coincident step: code and wrap stay untouched.
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    num_d   = step_num(num_q, dir_q);
                    wrap_d  = is_wrap(num_q, dir_q);
                    steps_d = steps_q + 2'd1;
                    if (single_q && (steps_q == 2'd3)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            num_q    <= 2'd0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            dir_q    <= DIR_UP;
            single_q <= 1'b0;
            dwell_q  <= '0;
            steps_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
            dir_q    <= dir_d;
            single_q <= single_d;
            dwell_q  <= dwell_d;
            steps_q  <= steps_d;
        end
    end

    assign num  = num_q;
    assign busy = busy_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_num_sequencer.sv
// Self-checking bench for num_sequencer; exercises the preset feature when
// NUM_SEQ_LOAD_EN is defined.
module tb_num_sequencer;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          dir;
    logic          single;
    logic [DW-1:0] dwell;
`ifdef NUM_SEQ_LOAD_EN
    logic          load;
    logic [1:0]    load_val;
`endif
    logic [1:0]    num;
    logic          busy;
    logic          wrap;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 idle, 1 run, 2 done; position derived from edges since start.
    int m_state = 0;
    int m_num   = 0;
    int m_t     = 0;
    int m_n0    = 0;
    int m_d     = 0;
    bit m_dir   = 1'b0;
    bit m_single = 1'b0;
    bit e_wrap  = 1'b0;
    bit e_done  = 1'b0;

    num_sequencer #(.DWELL_W(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .single  (single),
        .dwell   (dwell),
`ifdef NUM_SEQ_LOAD_EN
        .load    (load),
        .load_val(load_val),
`endif
        .num     (num),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".num"},  32'(num),  32'(m_num));
        chk({tag, ".busy"}, 32'(busy), 32'(m_state == 1));
        chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    // Apply one rising edge to the model using the inputs present at that edge.
    task automatic model_edge();
        int s;
        int nn;
        e_wrap = 1'b0;
        e_done = 1'b0;
        case (m_state)
            0: begin
`ifdef NUM_SEQ_LOAD_EN
                if (load) begin
                    m_num = int'(load_val);
                end else
`endif
                if (start) begin
                    m_state  = 1;
                    m_t      = 0;
                    m_n0     = m_num;
                    m_dir    = dir;
                    m_single = single;
                    m_d      = int'(dwell);
                end
            end
            1: begin
                if (stop) begin
                    m_state = 0;
                end else begin
                    m_t++;
                    if (m_t % (m_d + 1) == 0) begin
                        s  = m_t / (m_d + 1);
                        nn = m_dir ? (((m_n0 - s) % 4) + 4) % 4 : (m_n0 + s) % 4;
                        e_wrap = (nn == (m_dir ? 3 : 0));
                        m_num  = nn;
                        if (m_single && s == 4) begin
                            m_state = 2;
                            e_done  = 1'b1;
                        end
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Raise reset between edges, check outputs cleared at once, release after one edge.
    task automatic do_async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        m_state = 0;
        m_num   = 0;
        e_wrap  = 1'b0;
        e_done  = 1'b0;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        dir    = 1'b0;
        single = 1'b0;
        dwell  = '0;
`ifdef NUM_SEQ_LOAD_EN
        load     = 1'b0;
        load_val = 2'd0;
`endif
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        check_all("reset_edge");
        rst = 1'b0;

        // Continuous count-up, one step per cycle, start on first edge after release.
        start = 1'b1; dir = 1'b0; single = 1'b0; dwell = '0;
        cycle("up0");
        start = 1'b0;
        repeat (10) cycle("up0");
        stop = 1'b1;
        cycle("stop");
        stop = 1'b0;
        repeat (2) cycle("idle");

        // Single down pass with dwell 2 from zero; inputs change after start.
        do_async_reset("rst_a");
        start = 1'b1; dir = 1'b1; single = 1'b1; dwell = DW'(2);
        cycle("down1");
        start = 1'b0; dir = 1'b0; single = 1'b0; dwell = '0;
        repeat (16) cycle("down1");
        chk("down1.end_num", 32'(num), 32'd0);

        // Stop coinciding with the second tick while showing 1.
        start = 1'b1; dir = 1'b0; single = 1'b0; dwell = DW'(1);
        cycle("stoptick");
        start = 1'b0;
        repeat (3) cycle("stoptick");
        stop = 1'b1;
        cycle("stoptick");
        stop = 1'b0;
        chk("stoptick.num", 32'(num), 32'd1);
        chk("stoptick.wrap", 32'(wrap), 32'd0);
        chk("stoptick.busy", 32'(busy), 32'd0);

        // Reset in the middle of a run showing 2.
        start = 1'b1; dir = 1'b0; single = 1'b0; dwell = '0;
        cycle("midrst");
        start = 1'b0;
        cycle("midrst");
        chk("midrst.pre_num", 32'(num), 32'd2);
        do_async_reset("midrst");
        repeat (6) cycle("post_rst");

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            start  = ($urandom_range(0, 7) == 0);
            stop   = ($urandom_range(0, 15) == 0);
            dir    = 1'($urandom_range(0, 1));
            single = 1'($urandom_range(0, 1));
            dwell  = DW'($urandom_range(0, 3));
`ifdef NUM_SEQ_LOAD_EN
            load     = ($urandom_range(0, 15) == 0);
            load_val = 2'($urandom_range(0, 3));
`endif
            cycle("rand");
            if (i % 150 == 149) begin
                start = 1'b0;
                stop  = 1'b0;
                do_async_reset("rand");
            end
        end
        start = 1'b0;
        stop  = 1'b0;

`ifdef NUM_SEQ_LOAD_EN
        // Return to idle, then preset with a coincident start.
        load = 1'b0;
        stop = 1'b1;
        repeat (2) cycle("to_idle");
        stop = 1'b0;
        load = 1'b1; load_val = 2'd3; start = 1'b1;
        cycle("load");
        chk("load.num", 32'(num), 32'd3);
        chk("load.busy", 32'(busy), 32'd0);
        // Preset requested during a run has no effect.
        load = 1'b0; start = 1'b1; dir = 1'b0; single = 1'b0; dwell = DW'(3);
        cycle("load_run");
        start = 1'b0; load = 1'b1; load_val = 2'd0;
        repeat (3) cycle("load_run");
        chk("load_run.num", 32'(num), 32'd3);
        load = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/num_sequencer.md
NUM_SEQUENCER -- requirements
Module: num_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 4, width of dwell count.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin sequencing (sampled per cycle).
REQ-005 SHALL have port stop  input  1  abort sequencing.
REQ-006 SHALL have port dir  input  1  0 = count up, 1 = count down; latched at start.
REQ-007 SHALL have port single  input  1  1 = one pass of four steps, 0 = continuous; latched at start.
REQ-008 SHALL have port dwell  input  DWELL_W  cycles per step minus one; latched at start.
REQ-009 SHALL have port load  input  1  preset request (NUM_SEQ_LOAD_EN only).
REQ-010 SHALL have port load_val  input  2  preset value (NUM_SEQ_LOAD_EN only).
REQ-011 SHALL have port num  output  2  code driven to the downstream 2-to-4 decoder.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse on 3->0 (up) or 0->3 (down).
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of a single pass.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: num holds; start=1 -> RUN next cycle, latching dir, single, dwell into dir_q, single_q, dwell_q, and loading the dwell counter with dwell.
REQ-017 RUN: dwell counter decrements each cycle; at 0 it issues a step and reloads dwell_q.
REQ-018 Step SHALL be num +1 mod 4 (dir_q=0) or -1 mod 4 (dir_q=1); first step appears dwell+1 cycles after the start cycle; dwell=0 steps every cycle.
REQ-019 wrap SHALL assert in the cycle num shows the wrapped value, and only then.
REQ-020 single_q=1: after the 4th step (num equals its value at start), RUN -> DONE; done=1 for one cycle, then IDLE.
REQ-021 single_q=0: RUN continues indefinitely; done never asserts.
REQ-022 stop=1 in RUN SHALL force IDLE next cycle, take priority over a coincident step (no num change, no wrap).
REQ-023 start during RUN or DONE SHALL be ignored; stop in IDLE or DONE SHALL be ignored.
REQ-024 busy SHALL equal (state==RUN).

Reset
REQ-025 rst=1 SHALL immediately force IDLE, num=0, busy=0, wrap=0, done=0, dwell counter=0, dir_q=0, single_q=0, dwell_q=0, regardless of the clock.
REQ-026 Reset asserted mid-RUN SHALL abort the sequence; no done or wrap pulse after release.
REQ-027 After rst deassertion, the first start is honoured on the first rising edge.

Configuration
REQ-028 Macro NUM_SEQ_LOAD_EN defined: load/load_val ports exist; load=1 in IDLE sets num=load_val next cycle; load in RUN/DONE ignored; load and start in the same IDLE cycle -> load applies, start ignored.
REQ-029 Macro undefined: load/load_val ports absent; num only changes by stepping or reset.

Structure
REQ-030 Package num_seq_pkg SHALL hold the state typedef (IDLE, RUN, DONE) and constants DIR_UP=0, DIR_DOWN=1.
REQ-031 Sub-module dwell_timer SHALL implement the reloadable down counter with a tick output, parameterised by DWELL_W.

Verification
REQ-032 Reset, start with dir=0, single=0, dwell=0 -> num 0,1,2,3,0,... one per cycle; wrap pulses on each 3->0.
REQ-033 dir=1, single=1, dwell=2 from num=0 -> num 3,2,1,0 each 3 cycles apart; done pulses once, busy drops, wrap on 0->3.
REQ-034 stop coincident with a step tick at num=1 -> num stays 1, IDLE next cycle, no wrap.
REQ-035 rst asserted mid-RUN with num=2 -> num=0, busy=0 without a clock edge; no done after release.
REQ-036 NUM_SEQ_LOAD_EN: load=1, load_val=3 with start=1 in IDLE -> num=3, busy stays 0; load during RUN -> no effect.
